// File: rtl/cam_cache_rr.sv
// Fully associative tag/data cache: one-cycle registered lookup, write-allocate with round-robin
// victim selection, invalidate-by-tag, occupancy count and eviction report. Macro CAM_CACHE_STATS_EN adds hit/miss counters.
module cam_cache_rr #(
  parameter int WORDS     = 8,
  parameter int BITS      = 8,
  parameter int TAG_SZ    = 8,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1,
  parameter int CNT_W     = $clog2(WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              read,
  input  logic [TAG_SZ-1:0] check_tag,
  input  logic              write_,
  input  logic [TAG_SZ-1:0] new_tag,
  input  logic [BITS-1:0]   wdata,
  input  logic              inval,
  output logic [BITS-1:0]   data,
  output logic              found_it,
  output logic              rd_valid,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              evict,
  output logic [TAG_SZ-1:0] evict_tag
`ifdef CAM_CACHE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int IDX_W = ADDR_LEFT + 1;

  logic [WORDS-1:0]  val_q, val_d;
  logic [TAG_SZ-1:0] tag_q [WORDS];
  logic [BITS-1:0]   mem_q [WORDS];
  logic [IDX_W-1:0]  rr_q;

  logic [BITS-1:0]   data_q;
  logic              found_q;
  logic              rd_valid_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q;
  logic              evict_q;
  logic [TAG_SZ-1:0] evict_tag_q;

  logic [WORDS-1:0]  rd_hit, wr_hit;
  logic              rd_any, wr_any, free_any;
  logic [IDX_W-1:0]  rd_idx, wr_idx, free_idx, wr_sel;
  logic              write_en, inval_en, wr_case3;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_match
      assign rd_hit[gi] = val_q[gi] && (tag_q[gi] == check_tag);
      assign wr_hit[gi] = val_q[gi] && (tag_q[gi] == new_tag);
    end
  endgenerate

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    rd_any   = 1'b0;
    rd_idx   = '0;
    wr_any   = 1'b0;
    wr_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (rd_hit[i]) begin
        rd_any = 1'b1;
        rd_idx = IDX_W'(i);
      end
      if (wr_hit[i]) begin
        wr_any = 1'b1;
        wr_idx = IDX_W'(i);
      end
      if (!val_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    write_en = !write_;
    inval_en = inval && write_;
    wr_case3 = !wr_any && !free_any;
    wr_sel   = wr_any ? wr_idx : (free_any ? free_idx : rr_q);
    val_d    = val_q;
    if (write_en) begin
      val_d[wr_sel] = 1'b1;
    end else if (inval_en) begin
      val_d = val_q & ~rd_hit;
    end
    count_d = '0;
    for (int i = 0; i < WORDS; i++) begin
      count_d = count_d + CNT_W'(val_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      val_q       <= '0;
      rr_q        <= '0;
      data_q      <= '0;
      found_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      count_q     <= '0;
      full_q      <= 1'b0;
      evict_q     <= 1'b0;
      evict_tag_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        tag_q[i] <= '0;
        mem_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= read;
      if (read) begin
        data_q  <= rd_any ? mem_q[rd_idx] : '0;
        found_q <= rd_any;
      end
      val_q   <= val_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(WORDS));
      evict_q <= write_en && wr_case3;
      if (write_en) begin
        tag_q[wr_sel] <= new_tag;
        mem_q[wr_sel] <= wdata;
        if (wr_case3) begin
          evict_tag_q <= tag_q[rr_q];
          rr_q        <= (rr_q == IDX_W'(WORDS - 1)) ? '0 : rr_q + IDX_W'(1);
        end
      end
    end
  end

`ifdef CAM_CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (stats_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (read) begin
      if (rd_any && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (!rd_any && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign data      = data_q;
  assign found_it  = found_q;
  assign rd_valid  = rd_valid_q;
  assign full      = full_q;
  assign count     = count_q;
  assign evict     = evict_q;
  assign evict_tag = evict_tag_q;

endmodule

// File: tb/tb_cam_cache_rr.sv
// Self-checking bench for cam_cache_rr: directed scenarios plus randomized traffic against a
// behavioural cache model. Stats checks compile in only with CAM_CACHE_STATS_EN.
module tb_cam_cache_rr;
  localparam int WORDS = 8;

  logic       clk = 1'b0;
  logic       rst_;
  logic       read;
  logic [7:0] check_tag;
  logic       write_;
  logic [7:0] new_tag;
  logic [7:0] wdata;
  logic       inval;
  logic [7:0] data;
  logic       found_it;
  logic       rd_valid;
  logic       full;
  logic [3:0] count;
  logic       evict;
  logic [7:0] evict_tag;
`ifdef CAM_CACHE_STATS_EN
  logic        stats_clr;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Behavioural model state
  bit       m_val  [WORDS];
  bit [7:0] m_tag  [WORDS];
  bit [7:0] m_data [WORDS];
  int       m_rr;
  bit [7:0] exp_data;
  bit       exp_found;
  bit       exp_rdv;
  int       exp_count;
  bit       exp_full;
  bit       exp_evict;
  bit [7:0] exp_evict_tag;

  always #5 clk = ~clk;

  cam_cache_rr dut (
    .clk       (clk),
    .rst_      (rst_),
    .read      (read),
    .check_tag (check_tag),
    .write_    (write_),
    .new_tag   (new_tag),
    .wdata     (wdata),
    .inval     (inval),
    .data      (data),
    .found_it  (found_it),
    .rd_valid  (rd_valid),
    .full      (full),
    .count     (count),
    .evict     (evict),
    .evict_tag (evict_tag)
`ifdef CAM_CACHE_STATS_EN
    ,
    .stats_clr (stats_clr),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) begin
      m_val[i]  = 0;
      m_tag[i]  = 0;
      m_data[i] = 0;
    end
    m_rr = 0;
    exp_data = 0; exp_found = 0; exp_rdv = 0;
    exp_count = 0; exp_full = 0; exp_evict = 0; exp_evict_tag = 0;
  endtask

  // Applies one edge worth of the cache rules; lookup uses contents before any write/invalidate.
  task automatic model_step(input bit rd, input bit [7:0] ctag, input bit wr_n,
                            input bit [7:0] ntag, input bit [7:0] wd, input bit inv);
    int slot;
    exp_rdv = rd;
    if (rd) begin
      slot = -1;
      for (int i = 0; i < WORDS; i++)
        if (slot < 0 && m_val[i] && m_tag[i] == ctag) slot = i;
      exp_found = (slot >= 0);
      exp_data  = (slot >= 0) ? m_data[slot] : 8'h00;
    end
    exp_evict = 0;
    if (!wr_n) begin
      slot = -1;
      for (int i = 0; i < WORDS; i++)
        if (slot < 0 && m_val[i] && m_tag[i] == ntag) slot = i;
      if (slot < 0)
        for (int i = 0; i < WORDS; i++)
          if (slot < 0 && !m_val[i]) slot = i;
      if (slot < 0) begin
        slot = m_rr;
        exp_evict = 1;
        exp_evict_tag = m_tag[m_rr];
        m_rr = (m_rr + 1) % WORDS;
      end
      m_val[slot] = 1; m_tag[slot] = ntag; m_data[slot] = wd;
    end else if (inv) begin
      for (int i = 0; i < WORDS; i++)
        if (m_tag[i] == ctag) m_val[i] = 0;
    end
    exp_count = 0;
    for (int i = 0; i < WORDS; i++) exp_count += m_val[i];
    exp_full = (exp_count == WORDS);
  endtask

  task automatic cyc(input bit rd, input bit [7:0] ctag, input bit wr_n,
                     input bit [7:0] ntag, input bit [7:0] wd, input bit inv);
    read = rd; check_tag = ctag; write_ = wr_n; new_tag = ntag; wdata = wd; inval = inv;
    model_step(rd, ctag, wr_n, ntag, wd, inv);
    @(posedge clk); #1;
    n_txn++;
    $display("txn %0d rd=%0b ctag=%h wr_n=%0b ntag=%h wd=%h inv=%0b -> data=%h hit=%0b rdv=%0b cnt=%0d full=%0b ev=%0b evtag=%h",
             n_txn, rd, ctag, wr_n, ntag, wd, inv, data, found_it, rd_valid, count, full, evict, evict_tag);
  endtask

  task automatic idle();
    cyc(0, 8'h00, 1, 8'h00, 8'h00, 0);
  endtask

  task automatic apply_reset();
    read = 0; check_tag = 0; write_ = 1; new_tag = 0; wdata = 0; inval = 0;
`ifdef CAM_CACHE_STATS_EN
    stats_clr = 0;
`endif
    rst_ = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1;
    model_reset();
  endtask

  task automatic test_reset();
    read = 0; check_tag = 0; write_ = 1; new_tag = 0; wdata = 0; inval = 0;
`ifdef CAM_CACHE_STATS_EN
    stats_clr = 0;
`endif
    rst_ = 0;
    #1;
    n_checks++; if ({data, found_it, rd_valid, full, count, evict, evict_tag} !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs: got data=%h hit=%b rdv=%b full=%b cnt=%0d ev=%b evtag=%h, need all 0",
                         data, found_it, rd_valid, full, count, evict, evict_tag);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1;
    model_reset();
    cyc(1, 8'h00, 1, 8'h00, 8'h00, 0);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL reset_read_rdv: got %b need 1", rd_valid); end
    n_checks++; if (found_it !== 1'b0) begin n_fail++; $display("FAIL reset_read_hit: got %b need 0", found_it); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_read_data: got %h need 00", data); end
    n_checks++; if (count !== 4'd0 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_read_count: got cnt=%0d full=%b need 0/0", count, full);
    end
    idle();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rdv_drop: got %b need 0", rd_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < WORDS; i++) begin
      cyc(0, 8'h00, 0, 8'h11 + 8'(i), 8'hA1 + 8'(i), 0);
      n_checks++; if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d need %0d", i, count, i + 1); end
      n_checks++; if (evict !== 1'b0) begin n_fail++; $display("FAIL fill_evict[%0d]: got %b need 0", i, evict); end
      n_checks++; if (full !== (i == WORDS - 1)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b need %b", i, full, i == WORDS - 1); end
    end
    cyc(1, 8'h15, 1, 8'h00, 8'h00, 0);
    n_checks++; if (data !== 8'hA5 || found_it !== 1'b1) begin
      n_fail++; $display("FAIL fill_read15: got data=%h hit=%b need A5/1", data, found_it);
    end
  endtask

  task automatic test_evict();
    cyc(0, 8'h00, 0, 8'h20, 8'hB0, 0);
    n_checks++; if (evict !== 1'b1 || evict_tag !== 8'h11) begin
      n_fail++; $display("FAIL evict_first: got ev=%b tag=%h need 1/11", evict, evict_tag);
    end
    idle();
    n_checks++; if (evict !== 1'b0 || evict_tag !== 8'h11) begin
      n_fail++; $display("FAIL evict_pulse: got ev=%b tag=%h need 0/11", evict, evict_tag);
    end
    cyc(0, 8'h00, 0, 8'h21, 8'hB1, 0);
    n_checks++; if (evict !== 1'b1 || evict_tag !== 8'h12) begin
      n_fail++; $display("FAIL evict_second: got ev=%b tag=%h need 1/12", evict, evict_tag);
    end
    cyc(1, 8'h11, 1, 8'h00, 8'h00, 0);
    n_checks++; if (found_it !== 1'b0 || data !== 8'h00) begin
      n_fail++; $display("FAIL evicted_read11: got hit=%b data=%h need 0/00", found_it, data);
    end
    cyc(1, 8'h20, 1, 8'h00, 8'h00, 0);
    n_checks++; if (found_it !== 1'b1 || data !== 8'hB0) begin
      n_fail++; $display("FAIL replaced_read20: got hit=%b data=%h need 1/B0", found_it, data);
    end
  endtask

  task automatic test_update();
    cyc(0, 8'h00, 0, 8'h13, 8'hCC, 0);
    n_checks++; if (count !== 4'd8 || evict !== 1'b0) begin
      n_fail++; $display("FAIL update_hit: got cnt=%0d ev=%b need 8/0", count, evict);
    end
    cyc(1, 8'h13, 1, 8'h00, 8'h00, 0);
    n_checks++; if (data !== 8'hCC || found_it !== 1'b1) begin
      n_fail++; $display("FAIL update_read13: got data=%h hit=%b need CC/1", data, found_it);
    end
    // Victim must still be entry 2 (tag 13) since the update did not move the pointer.
    cyc(0, 8'h00, 0, 8'h22, 8'hB2, 0);
    n_checks++; if (evict !== 1'b1 || evict_tag !== 8'h13) begin
      n_fail++; $display("FAIL rr_unchanged: got ev=%b tag=%h need 1/13", evict, evict_tag);
    end
  endtask

  task automatic test_inval();
    cyc(0, 8'h14, 1, 8'h00, 8'h00, 1);
    n_checks++; if (count !== 4'd7 || full !== 1'b0 || evict !== 1'b0) begin
      n_fail++; $display("FAIL inval_14: got cnt=%0d full=%b ev=%b need 7/0/0", count, full, evict);
    end
    cyc(0, 8'h00, 0, 8'h30, 8'hD0, 0);
    n_checks++; if (count !== 4'd8 || full !== 1'b1 || evict !== 1'b0) begin
      n_fail++; $display("FAIL fill_free_slot: got cnt=%0d full=%b ev=%b need 8/1/0", count, full, evict);
    end
    cyc(0, 8'h16, 0, 8'h15, 8'h55, 1);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL write_beats_inval_cnt: got %0d need 8", count); end
    cyc(1, 8'h16, 1, 8'h00, 8'h00, 0);
    n_checks++; if (found_it !== 1'b1 || data !== 8'hA6) begin
      n_fail++; $display("FAIL write_beats_inval_read: got hit=%b data=%h need 1/A6", found_it, data);
    end
    cyc(1, 8'h15, 0, 8'h15, 8'h77, 0);
    n_checks++; if (data !== 8'h55) begin n_fail++; $display("FAIL read_before_write: got %h need 55", data); end
    cyc(1, 8'h15, 1, 8'h00, 8'h00, 0);
    n_checks++; if (data !== 8'h77) begin n_fail++; $display("FAIL read_after_write: got %h need 77", data); end
    cyc(0, 8'h99, 1, 8'h00, 8'h00, 1);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL inval_miss: got cnt=%0d need 8", count); end
  endtask

  task automatic test_reset_mid();
    read = 1; check_tag = 8'h15; write_ = 1; inval = 0;
    @(negedge clk);
    rst_ = 0;
    #1;
    n_checks++; if ({data, found_it, rd_valid, full, count, evict, evict_tag} !== 24'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got data=%h hit=%b rdv=%b full=%b cnt=%0d ev=%b evtag=%h, need all 0",
                         data, found_it, rd_valid, full, count, evict, evict_tag);
    end
    @(posedge clk); #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_rdv: got %b need 0", rd_valid); end
    read = 0;
    @(negedge clk);
    rst_ = 1;
    model_reset();
    cyc(1, 8'h15, 1, 8'h00, 8'h00, 0);
    n_checks++; if (found_it !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL midreset_cleared: got hit=%b cnt=%0d need 0/0", found_it, count);
    end
  endtask

  task automatic test_random();
    bit rd, wr_n, inv;
    bit [7:0] ctag, ntag, wd;
    int sel;
    for (int k = 0; k < 300; k++) begin
      rd   = 1'($urandom_range(0, 1));
      ctag = 8'h40 + 8'($urandom_range(0, 11));
      ntag = 8'h40 + 8'($urandom_range(0, 11));
      wd   = 8'($urandom);
      sel  = $urandom_range(0, 9);
      wr_n = (sel >= 4);
      inv  = (sel == 3) || (sel >= 8);
      cyc(rd, ctag, wr_n, ntag, wd, inv);
      n_checks++; if (rd_valid !== exp_rdv || found_it !== exp_found || data !== exp_data) begin
        n_fail++; $display("FAIL rand_lookup[%0d]: got rdv=%b hit=%b data=%h need %b/%b/%h",
                           k, rd_valid, found_it, data, exp_rdv, exp_found, exp_data);
      end
      n_checks++; if (count !== 4'(exp_count) || full !== exp_full) begin
        n_fail++; $display("FAIL rand_count[%0d]: got cnt=%0d full=%b need %0d/%b", k, count, full, exp_count, exp_full);
      end
      n_checks++; if (evict !== exp_evict || evict_tag !== exp_evict_tag) begin
        n_fail++; $display("FAIL rand_evict[%0d]: got ev=%b tag=%h need %b/%h", k, evict, evict_tag, exp_evict, exp_evict_tag);
      end
    end
  endtask

`ifdef CAM_CACHE_STATS_EN
  task automatic test_stats();
    apply_reset();
    cyc(0, 8'h00, 0, 8'h11, 8'hA1, 0);
    cyc(0, 8'h00, 0, 8'h12, 8'hA2, 0);
    cyc(1, 8'h11, 1, 8'h00, 8'h00, 0);
    cyc(1, 8'h12, 1, 8'h00, 8'h00, 0);
    cyc(1, 8'h99, 1, 8'h00, 8'h00, 0);
    cyc(1, 8'h11, 1, 8'h00, 8'h00, 0);
    cyc(1, 8'h98, 1, 8'h00, 8'h00, 0);
    idle();
    n_checks++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
      n_fail++; $display("FAIL stats_count: got hit=%0d miss=%0d need 3/2", hit_cnt, miss_cnt);
    end
    stats_clr = 1;
    cyc(1, 8'h11, 1, 8'h00, 8'h00, 0);
    stats_clr = 0;
    n_checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stats_clr: got hit=%0d miss=%0d need 0/0", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_evict();
    test_update();
    test_inval();
    test_reset_mid();
    apply_reset();
    test_random();
`ifdef CAM_CACHE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_cache_rr.md
Name: cam_cache_rr

Overview:
- Parametrised successor to the team's CAM-based cache: fully associative tag/data store with registered one-cycle lookup.
- Writes allocate automatically: update on hit, else first free slot, else a round-robin victim.
- Adds tag-based invalidate, occupancy count and eviction reporting.
- Sits between the requester and backing memory as a small fully associative cache.

Parameters:
- WORDS, 8, number of entries (power of two, >=2)
- BITS, 8, data width per entry
- TAG_SZ, 8, tag width
- ADDR_LEFT, $clog2(WORDS)-1, MSB of an entry index
- CNT_W, $clog2(WORDS+1), width of the occupancy count

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_  input  1  asynchronous active-low reset
- read  input  1  lookup strobe
- check_tag  input  TAG_SZ  tag to look up
- write_  input  1  active-low write/allocate strobe
- new_tag  input  TAG_SZ  tag to write
- wdata  input  BITS  data to write
- inval  input  1  active-high invalidate-by-tag strobe, uses check_tag
- data  output  BITS  lookup data, registered
- found_it  output  1  lookup hit, registered
- rd_valid  output  1  pulses one cycle after read
- full  output  1  all entries valid
- count  output  CNT_W  number of valid entries
- evict  output  1  registered pulse: last write replaced a valid entry with a different tag
- evict_tag  output  TAG_SZ  tag that was evicted, held until the next eviction

Behaviour:
- Reset (async, rst_=0):
  - all val bits, tag and data memories, and the round-robin pointer clear to 0
  - data=0, found_it=0, rd_valid=0, full=0, count=0, evict=0, evict_tag=0
- Lookup:
  - read=1 at edge N -> data/found_it/rd_valid valid after edge N+1 (latency 1)
  - hit = val[i] && tag[i]==check_tag; lowest index wins on duplicates
  - miss -> data=0, found_it=0
  - read=0 -> rd_valid=0; data and found_it hold their previous values
- Write (write_=0), priority order:
  - (1) new_tag hits a valid entry: overwrite that entry's data; evict=0
  - (2) otherwise: allocate the lowest-index invalid entry; evict=0
  - (3) otherwise (full): allocate the entry at rr_ptr; evict=1, evict_tag=old tag; rr_ptr <= rr_ptr+1, wrapping WORDS-1 -> 0
  - rr_ptr advances only in case (3)
- Invalidate (inval=1, write_=1): clear val of every entry whose tag matches check_tag; data and tag memories are untouched; no-op on miss.
- Simultaneous events:
  - write_=0 with inval=1: the write executes, inval is ignored that cycle
  - read with write/inval in the same cycle: the lookup sees pre-edge contents (read-before-write)
- count and full: registered, updated on the same edge as the val change; full = (count==WORDS).
- evict: single-cycle pulse; low in any cycle without a case (3) write.
- Reset mid-operation: state clears immediately; a lookup in flight produces no rd_valid.

Optional Feature:
- Macro CAM_CACHE_STATS_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - incremented on each read that hits or misses respectively
  - saturate at 16'hFFFF
  - reset to 0
  - additionally cleared synchronously by input stats_clr (1 bit, highest priority over increment)
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then read check_tag=8'h00 -> rd_valid=1 next cycle, found_it=0, data=0, count=0, full=0.
- Write tags 8'h11..8'h18 with data 8'hA1..8'hA8 (WORDS=8) -> count increments 1..8, full=1 after the 8th write, evict never asserted; read 8'h15 -> data=8'hA5, found_it=1.
- When full, write tag 8'h20/data 8'hB0 -> entry 0 replaced, evict=1 for one cycle, evict_tag=8'h11; next write 8'h21 -> entry 1 replaced, evict_tag=8'h12; read 8'h11 -> found_it=0.
- Write existing tag 8'h13 with 8'hCC -> count unchanged, evict=0, rr_ptr unchanged; read 8'h13 -> 8'hCC.
- inval with check_tag=8'h14 -> count 8->7, full=0; next write 8'h30 fills entry 3 (free slot) with evict=0; same-cycle write_=0 and inval=1 -> invalidate ignored.
- Assert rst_ low mid-burst (read pending) -> all outputs 0 immediately, no rd_valid pulse; with CAM_CACHE_STATS_EN, 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2, stats_clr -> both 0.
